// File: rtl/pci_target_burst_ctl_if.sv
// Bus bundle between the PCI pad ring (master side) and the target data-phase controller (slave side).
interface pci_target_burst_ctl_if #(
  parameter int ADDR_W = 30
);
  logic              frame;
  logic              irdy;
  logic              hit;
  logic [ADDR_W-1:0] ad_addr;
  logic              be_ready;
  logic              ce_force;
  logic              devsel;
  logic              trdy;
  logic              stop;
  logic              ctl_oe;
  logic              pci_ce;
  logic [ADDR_W-1:0] xfer_addr;
  logic [7:0]        xfer_cnt;
  logic              busy;

  modport slave (
    input  frame, irdy, hit, ad_addr, be_ready, ce_force,
    output devsel, trdy, stop, ctl_oe, pci_ce, xfer_addr, xfer_cnt, busy
  );

  modport master (
    output frame, irdy, hit, ad_addr, be_ready, ce_force,
    input  devsel, trdy, stop, ctl_oe, pci_ce, xfer_addr, xfer_cnt, busy
  );
endinterface

// File: rtl/pci_target_burst_ctl.sv
// PCI target data-phase controller: claims decoded transactions, paces TRDY# with initial and
// backend wait states, counts transfers and disconnects after a configurable burst length.
module pci_target_burst_ctl #(
  parameter int ADDR_W      = 30,
  parameter int WAIT_STATES = 1,
  parameter int BURST_MAX   = 16
) (
  input logic                  clk,
  input logic                  rst,
  pci_target_burst_ctl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SKIP, ACTIVE, DISC, TURN} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  localparam bit         DISC_EN   = (BURST_MAX != 0);

  state_t            state, state_next;
  logic              frame_q;
  logic [3:0]        wait_cnt, wait_next, wait_dec;
  logic              devsel_q, devsel_next;
  logic              trdy_q, trdy_next;
  logic              stop_q, stop_next;
  logic              ctl_oe_q, ctl_oe_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [7:0]        cnt_q, cnt_next, cnt_inc;
  logic              xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      frame_q  <= 1'b1;
      wait_cnt <= 4'd0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ctl_oe_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state    <= state_next;
      frame_q  <= bus.frame;
      wait_cnt <= wait_next;
      devsel_q <= devsel_next;
      trdy_q   <= trdy_next;
      stop_q   <= stop_next;
      ctl_oe_q <= ctl_oe_next;
      addr_q   <= addr_next;
      cnt_q    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    devsel_next = devsel_q;
    trdy_next   = trdy_q;
    stop_next   = stop_q;
    ctl_oe_next = ctl_oe_q;
    addr_next   = addr_q;
    cnt_next    = cnt_q;
    xfer        = !bus.irdy && !trdy_q;
    wait_dec    = (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
    cnt_inc     = cnt_q + 8'd1;

    case (state)
      IDLE: begin
        if (!bus.frame && frame_q) begin
          if (bus.hit) begin
            addr_next   = bus.ad_addr;
            cnt_next    = 8'd0;
            wait_next   = WAIT_INIT;
            devsel_next = 1'b0;
            ctl_oe_next = 1'b1;
            state_next  = ACTIVE;
          end else begin
            state_next = SKIP;
          end
        end
      end

      SKIP: begin
        if (bus.frame && bus.irdy) state_next = IDLE;
      end

      ACTIVE: begin
        wait_next = wait_dec;
        if (xfer) begin
          cnt_next  = cnt_inc;
          addr_next = addr_q + 1'b1;
        end
        // Exits are checked in priority order; a held TRDY# is only re-evaluated after it completes a transfer.
        if ((xfer && bus.frame) || (!xfer && bus.frame && bus.irdy)) begin
          devsel_next = 1'b1;
          trdy_next   = 1'b1;
          stop_next   = 1'b1;
          state_next  = TURN;
        end else if (xfer && DISC_EN && (cnt_inc == BURST_LIM)) begin
          trdy_next  = 1'b1;
          stop_next  = 1'b0;
          state_next = DISC;
        end else if (trdy_q || xfer) begin
          trdy_next = !((wait_dec == 4'd0) && bus.be_ready);
        end
      end

      DISC: begin
        if (bus.frame) begin
          devsel_next = 1'b1;
          trdy_next   = 1'b1;
          stop_next   = 1'b1;
          state_next  = TURN;
        end
      end

      TURN: begin
        ctl_oe_next = 1'b0;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.devsel    = devsel_q;
  assign bus.trdy      = trdy_q;
  assign bus.stop      = stop_q;
  assign bus.ctl_oe    = ctl_oe_q;
  assign bus.xfer_addr = addr_q;
  assign bus.xfer_cnt  = cnt_q;
  assign bus.busy      = (state != IDLE);
  assign bus.pci_ce    = bus.ce_force | (!bus.irdy & !trdy_q);

endmodule

// File: tb/tb_pci_target_burst_ctl.sv
// Bench for pci_target_burst_ctl: a vector table scored through a queue on a BURST_MAX=16 instance,
// plus hand sequences for async reset, a BURST_MAX=3 instance and address wrap.
module tb_pci_target_burst_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame, irdy, hit, be_ready, ce_force;
  logic [29:0] ad_addr;

  always #5 clk = ~clk;

  pci_target_burst_ctl_if #(.ADDR_W(30)) bus_a ();
  pci_target_burst_ctl_if #(.ADDR_W(8))  bus_b ();

  assign bus_a.frame    = frame;
  assign bus_a.irdy     = irdy;
  assign bus_a.hit      = hit;
  assign bus_a.be_ready = be_ready;
  assign bus_a.ce_force = ce_force;
  assign bus_a.ad_addr  = ad_addr;
  assign bus_b.frame    = frame;
  assign bus_b.irdy     = irdy;
  assign bus_b.hit      = hit;
  assign bus_b.be_ready = be_ready;
  assign bus_b.ce_force = ce_force;
  assign bus_b.ad_addr  = ad_addr[7:0];

  pci_target_burst_ctl #(.ADDR_W(30), .WAIT_STATES(1), .BURST_MAX(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  pci_target_burst_ctl #(.ADDR_W(8), .WAIT_STATES(1), .BURST_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.devsel, bus_a.trdy, bus_a.stop, bus_a.ctl_oe, bus_a.busy};
  assign ctl_b = {bus_b.devsel, bus_b.trdy, bus_b.stop, bus_b.ctl_oe, bus_b.busy};

  // Control vector {devsel, trdy, stop, ctl_oe, busy} for each visible controller phase.
  localparam logic [4:0] IDLE_C = 5'b11100;
  localparam logic [4:0] ACT_W  = 5'b01111;
  localparam logic [4:0] ACT_T  = 5'b00111;
  localparam logic [4:0] TURN_C = 5'b11111;
  localparam logic [4:0] DISC_C = 5'b01011;
  localparam logic [4:0] SKIP_C = 5'b11101;

  typedef struct {
    logic        frame, irdy, hit, be_ready, ce_force;
    logic [29:0] ad_addr;
    logic        exp_ce;
    logic [4:0]  exp_ctl;
    logic [7:0]  exp_cnt;
    logic [29:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [4:0]  ctl;
    logic [7:0]  cnt;
    logic [29:0] addr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  function automatic void add_row(input logic f, input logic i, input logic h, input logic b,
                                  input logic c, input logic [29:0] a, input logic ce,
                                  input logic [4:0] ctl, input logic [7:0] cnt,
                                  input logic [29:0] addr);
    vec_t v;
    v.frame    = f;
    v.irdy     = i;
    v.hit      = h;
    v.be_ready = b;
    v.ce_force = c;
    v.ad_addr  = a;
    v.exp_ce   = ce;
    v.exp_ctl  = ctl;
    v.exp_cnt  = cnt;
    v.exp_addr = addr;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic f, input logic i, input logic h, input logic b,
                       input logic c, input logic [29:0] a);
    frame    = f;
    irdy     = i;
    hit      = h;
    be_ready = b;
    ce_force = c;
    ad_addr  = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    drive(v.frame, v.irdy, v.hit, v.be_ready, v.ce_force, v.ad_addr);
    e.ctl  = v.exp_ctl;
    e.cnt  = v.exp_cnt;
    e.addr = v.exp_addr;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    exp_t e;

    // Single data phase, one wait state.
    add_row(0,1,1,1,0,30'h100, 0, ACT_W,  8'd0, 30'h100);
    add_row(1,0,0,1,0,30'h0,   0, ACT_T,  8'd0, 30'h100);
    add_row(1,0,0,1,0,30'h0,   1, TURN_C, 8'd1, 30'h101);
    add_row(1,1,0,1,0,30'h0,   0, IDLE_C, 8'd1, 30'h101);
    // Long burst disconnected after 16 transfers.
    add_row(0,1,1,1,0,30'h200, 0, ACT_W,  8'd0, 30'h200);
    add_row(0,0,0,1,0,30'h0,   0, ACT_T,  8'd0, 30'h200);
    for (int k = 1; k <= 15; k++)
      add_row(0,0,0,1,0,30'h0, 1, ACT_T, 8'(k), 30'(32'h200 + k));
    add_row(0,0,0,1,0,30'h0,   1, DISC_C, 8'd16, 30'h210);
    for (int k = 0; k < 3; k++)
      add_row(0,0,0,1,0,30'h0, 0, DISC_C, 8'd16, 30'h210);
    add_row(1,0,0,1,0,30'h0,   0, TURN_C, 8'd16, 30'h210);
    add_row(1,1,0,1,0,30'h0,   0, IDLE_C, 8'd16, 30'h210);
    // Backend stalls: asserted TRDY# survives be_ready low.
    add_row(0,1,1,1,0,30'h300, 0, ACT_W,  8'd0, 30'h300);
    add_row(0,0,0,1,0,30'h0,   0, ACT_T,  8'd0, 30'h300);
    add_row(0,0,0,0,0,30'h0,   1, ACT_W,  8'd1, 30'h301);
    add_row(0,0,0,0,0,30'h0,   0, ACT_W,  8'd1, 30'h301);
    add_row(0,0,0,1,0,30'h0,   0, ACT_T,  8'd1, 30'h301);
    add_row(0,1,0,0,0,30'h0,   0, ACT_T,  8'd1, 30'h301);
    add_row(0,0,0,1,0,30'h0,   1, ACT_T,  8'd2, 30'h302);
    add_row(0,0,0,1,0,30'h0,   1, ACT_T,  8'd3, 30'h303);
    add_row(1,0,0,1,0,30'h0,   1, TURN_C, 8'd4, 30'h304);
    add_row(1,1,0,1,0,30'h0,   0, IDLE_C, 8'd4, 30'h304);
    // Decode miss.
    add_row(0,1,0,1,0,30'h999, 0, SKIP_C, 8'd4, 30'h304);
    add_row(0,0,0,1,0,30'h0,   0, SKIP_C, 8'd4, 30'h304);
    add_row(1,0,0,1,0,30'h0,   0, SKIP_C, 8'd4, 30'h304);
    add_row(1,1,0,1,0,30'h0,   0, IDLE_C, 8'd4, 30'h304);
    // Master abandons before any transfer, then forced clock enable while idle.
    add_row(0,1,1,0,0,30'h400, 0, ACT_W,  8'd0, 30'h400);
    add_row(1,1,0,0,0,30'h0,   0, TURN_C, 8'd0, 30'h400);
    add_row(1,1,0,1,1,30'h0,   1, IDLE_C, 8'd0, 30'h400);
    add_row(1,1,0,1,0,30'h0,   0, IDLE_C, 8'd0, 30'h400);

    rst = 1'b1;
    drive(1,1,0,1,0,30'h0);
    #2;
    checkOutput("reset_ctl", 32'(ctl_a), 32'(IDLE_C));
    checkOutput("reset_cnt", 32'(bus_a.xfer_cnt), 32'd0);
    checkOutput("reset_addr", 32'(bus_a.xfer_addr), 32'd0);
    checkOutput("reset_pci_ce", 32'(bus_a.pci_ce), 32'd0);
    ce_force = 1'b1;
    #1;
    checkOutput("reset_ce_force", 32'(bus_a.pci_ce), 32'd1);
    tick;
    ce_force = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d_pci_ce", i), 32'(bus_a.pci_ce), 32'(tbl[i].exp_ce));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        checkOutput($sformatf("row%0d_scoreboard_empty", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        checkOutput($sformatf("row%0d_ctl", i), 32'(ctl_a), 32'(e.ctl));
        checkOutput($sformatf("row%0d_cnt", i), 32'(bus_a.xfer_cnt), 32'(e.cnt));
        checkOutput($sformatf("row%0d_addr", i), 32'(bus_a.xfer_addr), 32'(e.addr));
      end
    end

    // Asynchronous reset in the middle of a burst.
    drive(0,1,1,1,0,30'h500);
    tick;
    drive(0,0,0,1,0,30'h0);
    tick;
    tick;
    checkOutput("pre_rst_cnt", 32'(bus_a.xfer_cnt), 32'd1);
    checkOutput("pre_rst_ctl", 32'(ctl_a), 32'(ACT_T));
    ce_force = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ctl", 32'(ctl_a), 32'(IDLE_C));
    checkOutput("async_rst_cnt", 32'(bus_a.xfer_cnt), 32'd0);
    checkOutput("async_rst_addr", 32'(bus_a.xfer_addr), 32'd0);
    checkOutput("async_rst_ce_force", 32'(bus_a.pci_ce), 32'd1);
    tick;
    drive(1,1,0,1,0,30'h0);
    rst = 1'b0;
    tick;
    checkOutput("post_rst_ctl", 32'(ctl_a), 32'(IDLE_C));

    // BURST_MAX=3 instance: third transfer is also the final data phase.
    drive(0,1,1,1,0,30'h10);
    tick;
    checkOutput("b3_claim_ctl", 32'(ctl_b), 32'(ACT_W));
    drive(0,0,0,1,0,30'h0);
    tick;
    checkOutput("b3_trdy_ctl", 32'(ctl_b), 32'(ACT_T));
    tick;
    checkOutput("b3_x1_ctl", 32'(ctl_b), 32'(ACT_T));
    checkOutput("b3_x1_cnt", 32'(bus_b.xfer_cnt), 32'd1);
    tick;
    checkOutput("b3_x2_ctl", 32'(ctl_b), 32'(ACT_T));
    drive(1,0,0,1,0,30'h0);
    tick;
    checkOutput("b3_last_ctl", 32'(ctl_b), 32'(TURN_C));
    checkOutput("b3_last_cnt", 32'(bus_b.xfer_cnt), 32'd3);
    checkOutput("b3_last_addr", 32'(bus_b.xfer_addr), 32'h13);
    drive(1,1,0,1,0,30'h0);
    tick;
    checkOutput("b3_idle_ctl", 32'(ctl_b), 32'(IDLE_C));

    // Address counter wrap on both widths.
    drive(0,1,1,1,0,30'h3FFF_FFFF);
    tick;
    checkOutput("wrap_a_start", 32'(bus_a.xfer_addr), 32'h3FFF_FFFF);
    checkOutput("wrap_b_start", 32'(bus_b.xfer_addr), 32'hFF);
    drive(1,0,0,1,0,30'h0);
    tick;
    tick;
    checkOutput("wrap_a_addr", 32'(bus_a.xfer_addr), 32'd0);
    checkOutput("wrap_a_cnt", 32'(bus_a.xfer_cnt), 32'd1);
    checkOutput("wrap_b_addr", 32'(bus_b.xfer_addr), 32'd0);
    checkOutput("wrap_b_ctl", 32'(ctl_b), 32'(TURN_C));
    drive(1,1,0,1,0,30'h0);
    tick;
    checkOutput("wrap_idle_ctl", 32'(ctl_a), 32'(IDLE_C));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pci_target_burst_ctl.md
Name: pci_target_burst_ctl

Overview:
- Parametrised successor to the PCI clock-enable primitive: a sequential PCI target data-phase controller.
- Tracks address phase and decode, and drives DEVSEL/TRDY/STOP with a configurable initial wait-state count and backend-paced waits.
- Generates PCI_CE per completed data phase and keeps a burst address and a transfer count.
- Issues a target disconnect at a configurable burst length. Sits between the PCI pad ring and the backend register/FIFO logic.

Parameters:
- ADDR_W, 30, width of the DWORD burst address counter.
- WAIT_STATES, 1, TRDY wait cycles after DEVSEL assertion before the first TRDY is allowed (0..15).
- BURST_MAX, 16, transfers per transaction before disconnect (1..255); 0 means never disconnect.

Ports:
- CLK  in  1  PCI clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- FRAME  in  1  PCI FRAME#, active-low.
- IRDY  in  1  PCI IRDY#, active-low.
- HIT  in  1  address decode match; valid in the address-phase cycle.
- AD_ADDR  in  ADDR_W  DWORD address; sampled in the address phase.
- BE_READY  in  1  backend can accept/supply data; gates TRDY assertion.
- CE_FORCE  in  1  unconditional clock-enable request, ORed into PCI_CE.
- DEVSEL  out  1  DEVSEL#, active-low, registered.
- TRDY  out  1  TRDY#, active-low, registered.
- STOP  out  1  STOP#, active-low, registered.
- CTL_OE  out  1  output enable for DEVSEL/TRDY/STOP pads, registered.
- PCI_CE  out  1  combinational: CE_FORCE | (!IRDY & !TRDY).
- XFER_ADDR  out  ADDR_W  address of the current data phase.
- XFER_CNT  out  8  transfers completed in the current transaction.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - DEVSEL=TRDY=STOP=1, CTL_OE=0, XFER_ADDR=0, XFER_CNT=0, BUSY=0.
  - state=IDLE; frame_q=1 (registered FRAME); wait counter=0.
- States: IDLE, SKIP, ACTIVE, DISC, TURN.
- Address phase: FRAME==0 while frame_q==1, sampled in IDLE.
- IDLE:
  - Address phase with HIT=1: XFER_ADDR<=AD_ADDR, XFER_CNT<=0, wait counter<=WAIT_STATES, DEVSEL<=0, CTL_OE<=1, go ACTIVE. DEVSEL is low in the first cycle after the address phase.
  - Address phase with HIT=0: go SKIP.
- SKIP: outputs stay idle; return to IDLE when FRAME==1 and IRDY==1.
- ACTIVE:
  - Wait counter decrements each cycle while nonzero.
  - xfer = !IRDY & !TRDY at the sampling edge.
  - On xfer: XFER_CNT+=1, XFER_ADDR+=1 (wraps mod 2^ADDR_W; XFER_CNT wraps at 255 only when BURST_MAX=0).
  - TRDY assertion: TRDY<=0 only when the wait counter is 0 (after this edge's decrement) and BE_READY=1.
  - Once TRDY is low it stays low until xfer. BE_READY going low never withdraws an asserted TRDY.
  - After xfer, TRDY is re-evaluated by the same rule, so back-to-back transfers are possible with no dead cycle.
- Exit priority from ACTIVE, highest first:
  1. xfer with FRAME==1 (final data phase): go TURN.
  2. FRAME==1 and IRDY==1 with no xfer (master gone): go TURN.
  3. xfer with FRAME==0 and new XFER_CNT==BURST_MAX (BURST_MAX≠0): STOP<=0, TRDY<=1, DEVSEL stays 0, go DISC.
- DISC: hold STOP=0, TRDY=1, DEVSEL=0; when FRAME sampled ==1, go TURN. No further transfers are counted.
- TRDY precedence: any transition to TURN or DISC forces TRDY<=1 regardless of BE_READY.
- TURN (one cycle): DEVSEL=TRDY=STOP=1, CTL_OE=1; then IDLE with CTL_OE<=0. XFER_CNT and XFER_ADDR hold their final values until the next hit.
- PCI_CE: purely combinational, no latency. CE_FORCE=1 gives PCI_CE=1 in any state, including reset.

Test Plan:
- Single write, WAIT_STATES=1, BE_READY=1, AD_ADDR=0x100, FRAME low 1 cycle, IRDY low cycle 1 -> DEVSEL low cycle 1, TRDY low cycle 2, one PCI_CE pulse, XFER_CNT=1, XFER_ADDR=0x101, TURN then CTL_OE=0.
- Burst of 20, BURST_MAX=16, IRDY held low, BE_READY=1 -> 16 PCI_CE pulses, STOP low the cycle after the 16th transfer, TRDY high, XFER_ADDR=base+16; release to IDLE after FRAME goes high.
- BE_READY toggling 1,0,0,1 during a 4-transfer burst -> asserted TRDY never withdrawn; TRDY reasserts only after BE_READY=1; exactly 4 transfers, XFER_CNT=4.
- Address phase with HIT=0 -> DEVSEL/TRDY/STOP stay high, CTL_OE=0, BUSY=1 until FRAME=IRDY=1; then IDLE.
- BURST_MAX=3 with the 3rd transfer coinciding with FRAME high -> normal TURN, STOP never asserted. Separately, XFER_ADDR=2^ADDR_W-1 plus one transfer -> wraps to 0.
- RST pulse mid-burst -> all outputs at reset values within the same cycle (async). CE_FORCE=1 during reset -> PCI_CE=1.
